// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared MIPS definitions (ALU ops, mul/div ops, mul/div states)
package mips_muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;

endpackage

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative radix-2 multiply/divide unit with HI/LO registers
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        state;
    md_op_t           opc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opr;
    logic             sa, sb, dz;

    logic               is_div, cap_sa, cap_sb;
    logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix;
    logic [WIDTH:0]     add_x, add_y, sum;
    logic [2*WIDTH-1:0] prod_neg;

    assign busy = (state != MD_IDLE);

    // operand magnitudes, the shared adder/subtractor and sign correction
    always_comb begin
        is_div   = (opc == MD_DIV) || (opc == MD_DIVU);
        cap_sa   = ~op[0] & a[WIDTH-1];
        cap_sb   = ~op[0] & b[WIDTH-1];
        mag_a    = cap_sa ? -a : a;
        mag_b    = cap_sb ? -b : b;
        add_x    = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
        add_y    = is_div ? ~{1'b0, opr} : (acc_lo[0] ? {1'b0, opr} : '0);
        sum      = add_x + add_y + {{WIDTH{1'b0}}, is_div};
        prod_neg = -{acc_hi, acc_lo};
        q_fix    = (sa ^ sb) ? -acc_lo : acc_lo;
        r_fix    = sa ? -acc_hi : acc_hi;
    end

    // control FSM, iteration datapath and HI/LO result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= MD_IDLE;
            opc         <= MD_MULT;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opr         <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        opc    <= md_op_t'(op);
                        sa     <= cap_sa;
                        sb     <= cap_sb;
                        opr    <= op[1] ? mag_b : mag_a;
                        acc_lo <= op[1] ? mag_a : mag_b;
                        acc_hi <= '0;
                        dz     <= op[1] && (b == '0);
                        cnt    <= CW'(WIDTH);
                        state  <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc_hi <= sum[WIDTH] ? add_x[WIDTH-1:0] : sum[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~sum[WIDTH]};
                    end else begin
                        acc_hi <= sum[WIDTH:1];
                        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CW'(1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= dz ? '1 : q_fix;
                    end else begin
                        {hi, lo} <= (sa ^ sb) ? prod_neg : {acc_hi, acc_lo};
                    end
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    state       <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed self-checking bench for mips_muldiv
module tb_mips_muldiv;
    logic        clk = 0, reset = 1, start = 0, hi_we = 0, lo_we = 0;
    logic [1:0]  op = 0;
    logic [31:0] a = 0, b = 0, wdata = 0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int total = 0, bad = 0;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // starts an operation at a negedge and returns cycles from start edge to done
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int k);
        op = o; a = x; b = y; start = 1;
        @(negedge clk);
        start = 0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (hi !== 0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_by_zero}); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int k;
        run(2'd0, 32'hFFFFFFFD, 32'd5, k);
        total++; if (k !== 33) begin bad++; $display("FAIL mult_latency got=%0d want=33", k); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_lo got=%h want=fffffff1", lo); end
        total++; if (busy !== 1'b0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL mult_flags got=%b%b want=00", busy, div_by_zero); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b want=0", done); end
        run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, k);
        total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin bad++; $display("FAIL multu got=%h_%h want=fffffffe_00000001", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div;
        int k;
        run(2'd3, 32'd100, 32'd7, k);
        total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL divu_100_7 got=%h_%h want=00000002_0000000e", hi, lo); end
        @(negedge clk);
        run(2'd2, 32'hFFFFFFF9, 32'd2, k);
        total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_m7_2 got=%h_%h want=ffffffff_fffffffd", hi, lo); end
        @(negedge clk);
        run(2'd2, 32'h80000000, 32'hFFFFFFFF, k);
        total++; if (lo !== 32'h80000000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL div_minneg got=%h_%h dz=%b want=00000000_80000000 dz=0", hi, lo, div_by_zero); end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        int k;
        run(2'd3, 32'h1234, 32'd0, k);
        total++; if (k !== 33) begin bad++; $display("FAIL dz_latency got=%0d want=33", k); end
        total++; if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin bad++; $display("FAIL dz_result got=%h_%h want=00001234_ffffffff", hi, lo); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
        @(negedge clk);
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_flag_clear got=%b want=0", div_by_zero); end
    endtask

    task automatic test_busy_ignore;
        int k;
        op = 2'd0; a = 32'd3; b = 32'd5; start = 1;
        @(negedge clk);
        start = 0;
        k = 0;
        while (!done && k < 100) begin
            if (k == 9) begin
                start = 1; op = 2'd3; a = 32'd77; b = 32'd0; hi_we = 1; wdata = 32'hAA;
            end
            @(negedge clk);
            start = 0; hi_we = 0;
            k++;
        end
        total++; if (k !== 33) begin bad++; $display("FAIL busy_latency got=%0d want=33", k); end
        total++; if (hi !== 32'h0 || lo !== 32'd15) begin bad++; $display("FAIL busy_result got=%h_%h want=00000000_0000000f", hi, lo); end
        hi_we = 1; wdata = 32'hAA;
        @(negedge clk);
        hi_we = 0;
        total++; if (hi !== 32'hAA || lo !== 32'd15) begin bad++; $display("FAIL idle_hi_we got=%h_%h want=000000aa_0000000f", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int k;
        run(2'd1, 32'd6, 32'd7, k);
        total++; if (lo !== 32'd42 || hi !== 32'd0) begin bad++; $display("FAIL b2b_first got=%h_%h want=00000000_0000002a", hi, lo); end
        run(2'd3, 32'd100, 32'd9, k);
        total++; if (k !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", k); end
        total++; if (lo !== 32'd11 || hi !== 32'd1) begin bad++; $display("FAIL b2b_second got=%h_%h want=00000001_0000000b", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_write_and_start;
        int k;
        hi_we = 1; lo_we = 1; wdata = 32'h55;
        op = 2'd0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1;
        @(negedge clk);
        start = 0; hi_we = 0; lo_we = 0;
        total++; if (hi !== 32'h55 || lo !== 32'h55 || busy !== 1'b1) begin bad++; $display("FAIL ws_write got=%h_%h busy=%b want=00000055_00000055 busy=1", hi, lo, busy); end
        k = 1;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++; if (hi !== 32'h0 || lo !== 32'h1) begin bad++; $display("FAIL ws_overwrite got=%h_%h want=00000000_00000001", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k, seen;
        op = 2'd2; a = 32'hFFFFFF9C; b = 32'd7; start = 1;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        #2 reset = 1;
        #1;
        total++; if (hi !== 0 || lo !== 0 || busy !== 1'b0) begin bad++; $display("FAIL midreset got=%h_%h busy=%b want=0_0 busy=0", hi, lo, busy); end
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midreset_done got=%0d want=0", seen); end
        run(2'd3, 32'd9, 32'd3, k);
        total++; if (lo !== 32'd3 || hi !== 32'd0 || k !== 33) begin bad++; $display("FAIL after_reset got=%h_%h k=%0d want=00000000_00000003 k=33", hi, lo, k); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_busy_ignore;
        test_back_to_back;
        test_write_and_start;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (even, >= 4).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 a, b  input  WIDTH  operands (multiplicand/dividend a; multiplier/divisor b), captured with start.
REQ-007 hi_we, lo_we  input  1  write wdata into HI / LO (mthi/mtlo path).
REQ-008 wdata  input  WIDTH  data for hi_we/lo_we.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse, high in the cycle after HI/LO are updated by an operation.
REQ-011 div_by_zero  output  1  high with done when the finished DIV/DIVU had b == 0; low otherwise.
REQ-012 hi, lo  output  WIDTH  registered HI and LO result registers.

Function
REQ-013 State machine SHALL have states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-014 In IDLE, start = 1 at edge t0 SHALL capture op, |a|, |b| (magnitudes for MULT/DIV; raw for MULTU/DIVU) and the operand signs, load the iteration counter with WIDTH, and enter RUN.
REQ-015 RUN SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes) for exactly WIDTH cycles, then enter FIX.
REQ-016 FIX SHALL apply sign correction, write HI/LO, and return to IDLE at edge t0+WIDTH+1; done SHALL be high in the following cycle only.
REQ-017 Multiply SHALL give HI:LO = full 2*WIDTH-bit product (signed for MULT, unsigned for MULTU).
REQ-018 Divide SHALL give LO = quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-019 DIV of most-negative value by -1 SHALL give LO = most-negative value, HI = 0, and no flag.
REQ-020 Divide with b == 0 SHALL take the normal latency and give LO = all ones, HI = a (as captured, raw), div_by_zero = 1 with done.
REQ-021 start while busy SHALL be ignored (no queueing); start in the done cycle SHALL be accepted.
REQ-022 hi_we/lo_we in IDLE SHALL write HI/LO at that edge; while busy they SHALL be dropped.
REQ-023 hi_we/lo_we and start at the same IDLE edge: the write SHALL take effect and the operation SHALL later overwrite both HI and LO.
REQ-024 Operand changes after the start edge SHALL not affect the result.

Reset
REQ-025 reset SHALL immediately force state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0.
REQ-026 reset asserted mid-operation SHALL abandon it with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-027 Op encodings (MD_MULT..MD_DIVU) and state encodings SHALL live in the shared MIPS definitions header alongside the ALU op codes.
REQ-028 The block SHALL be a single module; no sub-module is required, the datapath being one shared WIDTH+1-bit adder/subtractor.
REQ-029 The block SHALL be synthesizable with no latches and no multi-cycle combinational multiplier.

Verification (WIDTH = 32)
REQ-030 MULT a=0xFFFFFFFD (-3), b=5 -> done 33 cycles after start edge, HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy low at done.
REQ-031 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, div_by_zero=1 for one cycle with done.
REQ-034 Start MULT, pulse start and hi_we (wdata=0xAA) at cycle 10 -> both ignored, result unchanged; hi_we in IDLE -> hi=0xAA next cycle.
REQ-035 Assert reset at cycle 15 of a DIV -> hi=lo=0, busy=0 immediately, no done; new DIVU 9/3 after release -> LO=3, HI=0.
